key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, consecutive stable samples to accept a press or release (10 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, debounce/repeat counter width.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50000000, held cycles before first auto-repeat pulse; used only under KEY_REPEAT_EN.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 20000000, cycles between auto-repeat pulses; used only under KEY_REPEAT_EN.
REQ-005 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port key_in1  input  1  raw asynchronous button, active-high.
REQ-008 SHALL have port key_in0  input  1  raw asynchronous button, active-high.
REQ-009 SHALL have port EN_out1  output  1  one-cycle press pulse for key_in1; drives the mode-step counter's EN_in1.
REQ-010 SHALL have port EN_out0  output  1  one-cycle press pulse for key_in0; drives EN_in0.
REQ-011 SHALL have port key_state  output  2  debounced levels, bit1=key_in1, bit0=key_in0.

Function
REQ-012 SHALL pass each raw key through a 2-flop synchronizer before any other logic.
REQ-013 SHALL run one independent FSM per channel: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-014 IDLE: sync=1 -> PRESS_CHK, counter loaded with 1; else stay.
REQ-015 PRESS_CHK: sync=1 increments counter; sync=0 -> IDLE, no pulse; counter==DEB_CYCLES with sync=1 -> HELD.
REQ-016 The IDLE/PRESS_CHK->HELD transition SHALL register EN_outN high for exactly one cycle and set key_state bit to 1.
REQ-017 HELD: sync=0 -> REL_CHK, counter loaded with 1; REL_CHK mirrors PRESS_CHK: sync=1 -> HELD silently; DEB_CYCLES consecutive 0 samples -> IDLE, key_state bit cleared, no pulse.
REQ-018 Latency: raw input held high from before clk edge 1 -> EN_outN high in the cycle after edge DEB_CYCLES+2, low after edge DEB_CYCLES+3.
REQ-019 Glitch shorter than DEB_CYCLES samples in any check state SHALL produce no pulse and no key_state change.
REQ-020 Counter SHALL saturate, never wrap; compare is exact equality at CNT_W bits.
REQ-021 Simultaneous acceptance on both channels SHALL assert EN_out1 and EN_out0 in the same cycle.
REQ-022 One press SHALL yield exactly one pulse regardless of hold duration (repeat disabled).

Reset
REQ-023 rst_n low SHALL immediately force synchronizers 0, FSMs IDLE, counters 0, EN_out1=EN_out0=0, key_state=2'b00.
REQ-024 Reset asserted mid-check or mid-pulse SHALL abort without pulse; a key still held at release SHALL be debounced afresh and yield one pulse.

Configuration
REQ-025 With macro KEY_REPEAT_EN defined: in HELD, first extra pulse after REPEAT_DELAY held cycles, then one every REPEAT_PERIOD cycles until leaving HELD; repeat counter cleared on HELD entry.
REQ-026 Without KEY_REPEAT_EN: no repeat counter logic synthesized; REPEAT_* parameters ignored.

Structure
REQ-027 Shared package key_pkg SHALL hold the 2-bit state enum (IDLE, PRESS_CHK, HELD, REL_CHK) and default DEB_CYCLES/CNT_W constants.
REQ-028 Top SHALL instantiate sub-module key_debounce_ch twice (sync+FSM+counter per channel); top holds only wiring and key_state concatenation.

Verification (DEB_CYCLES=8, CNT_W=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-029 Clean press: key_in0 high 40 cycles -> single EN_out0 pulse after edge 10, key_state=2'b01, EN_out1 stays 0.
REQ-030 Bounce: key_in1 toggles every 3 cycles for 30 cycles, then stable high -> exactly one EN_out1 pulse, 10 edges after final stable edge.
REQ-031 Release bounce: while HELD, key_in0 low 5 cycles then high -> no pulse, key_state bit0 stays 1.
REQ-032 Simultaneous: both keys rise same cycle -> EN_out1 and EN_out0 high in same cycle, key_state=2'b11.
REQ-033 Reset mid-check: rst_n low at PRESS_CHK count 5 with key held -> outputs 0 at once; after release one pulse 10 edges later.
REQ-034 KEY_REPEAT_EN: key_in1 held 50 cycles -> pulses at edge 10, then 20 and 25 held cycles later, and every 5 cycles until release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default timing for the two-channel key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } key_state_e;

  localparam int unsigned DEB_CYCLES_DEF    = 1000000;
  localparam int unsigned CNT_W_DEF         = 20;
  localparam int unsigned REPEAT_DELAY_DEF  = 50000000;
  localparam int unsigned REPEAT_PERIOD_DEF = 20000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, press pulse and level.
// Auto-repeat in HELD is built only when KEY_REPEAT_EN is defined.
//
// state     | meaning
// IDLE      | key released and accepted as released
// PRESS_CHK | counting consecutive high samples
// HELD      | key accepted as pressed
// REL_CHK   | counting consecutive low samples
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] DEB_CMP = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       sync_q, sync_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic             key_s;

  assign key_s   = sync_q[1];
  assign sync_d  = {sync_q[0], key_raw};
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int          RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             rpt_first_q, rpt_first_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
`ifdef KEY_REPEAT_EN
    rpt_d       = '0;
    rpt_first_d = 1'b0;
    rpt_inc     = rpt_q + RPT_W'(1);
`endif
    case (state_q)
      IDLE: begin
        if (key_s) begin
          if (DEB_CMP == CNT_ONE) begin
            state_d = HELD;
            pulse_d = 1'b1;
            level_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_CMP) begin
          state_d = HELD;
          pulse_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!key_s) begin
          if (DEB_CMP == CNT_ONE) begin
            state_d = IDLE;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = REL_CHK;
            cnt_d   = CNT_ONE;
          end
        end
`ifdef KEY_REPEAT_EN
        // Repeat counter only survives while staying in HELD, so every entry starts at zero.
        else if (rpt_inc == (rpt_first_q ? RPT_NEXT : RPT_FIRST)) begin
          pulse_d     = 1'b1;
          rpt_d       = '0;
          rpt_first_d = 1'b1;
        end else begin
          rpt_d       = rpt_inc;
          rpt_first_d = rpt_first_q;
        end
`endif
      end
      REL_CHK: begin
        if (key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_CMP) begin
          state_d = IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/key_debounce.sv
// Two-channel key debouncer top: press pulses and debounced levels.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in1,
  input  logic       key_in0,
  output logic       EN_out1,
  output logic       EN_out0,
  output logic [1:0] key_state
);

  logic level1, level0;

  // The debounce threshold must be representable in the counter; repeat timing must be non-zero.
  if (DEB_CYCLES == 0 || DEB_CYCLES >= (1 << CNT_W) || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_cfg_err
    $error("key_debounce: invalid timing parameters");
  end

  key_debounce_ch #(
    .DEB_CYCLES   (DEB_CYCLES),
    .CNT_W        (CNT_W)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_ch1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(key_in1),
    .pulse  (EN_out1),
    .level  (level1)
  );

  key_debounce_ch #(
    .DEB_CYCLES   (DEB_CYCLES),
    .CNT_W        (CNT_W)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_ch0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(key_in0),
    .pulse  (EN_out0),
    .level  (level0)
  );

  assign key_state = {level1, level0};

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (DEB_CYCLES=8, CNT_W=4, REPEAT_DELAY=20, REPEAT_PERIOD=5).
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_in1 = 1'b0;
  logic       key_in0 = 1'b0;
  logic       EN_out1, EN_out0;
  logic [1:0] key_state;

  always #5 clk = ~clk;

  key_debounce #(
    .DEB_CYCLES   (8),
    .CNT_W        (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in1  (key_in1),
    .key_in0  (key_in0),
    .EN_out1  (EN_out1),
    .EN_out0  (EN_out0),
    .key_state(key_state)
  );

  typedef struct packed {
    int         at_edge;
    logic [1:0] en;
  } exp_t;

  exp_t exp_q[$];
  int   edge_n    = 0;
  int   tests_run = 0;
  int   fails     = 0;

  // Scoreboard: count rising edges, sample 2 ns later, match every pulse against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_n++;
      #2;
      while (exp_q.size() > 0 && exp_q[0].at_edge < edge_n) begin
        e = exp_q.pop_front();
        tests_run++;
        fails++;
        $display("FAIL missed_pulse: got none, expected EN=%b at edge %0d (now edge %0d)", e.en, e.at_edge, edge_n);
      end
      if ((EN_out1 | EN_out0) !== 1'b0) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: got EN=%b at edge %0d, expected none", {EN_out1, EN_out0}, edge_n);
        end else begin
          e = exp_q.pop_front();
          if (e.at_edge !== edge_n || e.en !== {EN_out1, EN_out0}) begin
            fails++;
            $display("FAIL pulse_match: got EN=%b at edge %0d, expected EN=%b at edge %0d",
                     {EN_out1, EN_out0}, edge_n, e.en, e.at_edge);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    key_in0 = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (EN_out0 !== 1'b0) begin fails++; $display("FAIL reset_en0: got %b, expected 0", EN_out0); end
    tests_run++;
    if (EN_out1 !== 1'b0) begin fails++; $display("FAIL reset_en1: got %b, expected 0", EN_out1); end
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b, expected 00", key_state); end
    key_in0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int base;
    @(negedge clk);
    key_in0 = 1'b1;
    base = edge_n;
    exp_q.push_back('{at_edge: base + 10, en: 2'b01});
`ifdef KEY_REPEAT_EN
    exp_q.push_back('{at_edge: base + 30, en: 2'b01});
    exp_q.push_back('{at_edge: base + 35, en: 2'b01});
    exp_q.push_back('{at_edge: base + 40, en: 2'b01});
`endif
    repeat (12) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b01) begin fails++; $display("FAIL press_state: got %b, expected 01", key_state); end
    repeat (28) @(negedge clk);
    key_in0 = 1'b0;
    base = edge_n;
    repeat (9) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b01) begin fails++; $display("FAIL release_early: got %b, expected 01", key_state); end
    @(negedge clk);
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL release_done: got %b, expected 00", key_state); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_glitch();
    int base;
    @(negedge clk);
    key_in0 = 1'b1;
    repeat (7) @(negedge clk);
    key_in0 = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL glitch7_state: got %b, expected 00", key_state); end
    key_in0 = 1'b1;
    base = edge_n;
    exp_q.push_back('{at_edge: base + 10, en: 2'b01});
    repeat (8) @(negedge clk);
    key_in0 = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL exact8_release: got %b, expected 00", key_state); end
  endtask

  task automatic test_release_bounce();
    int base;
    @(negedge clk);
    key_in0 = 1'b1;
    base = edge_n;
    exp_q.push_back('{at_edge: base + 10, en: 2'b01});
    repeat (14) @(negedge clk);
    key_in0 = 1'b0;
    repeat (5) @(negedge clk);
    key_in0 = 1'b1;
    repeat (12) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b01) begin fails++; $display("FAIL rel_bounce_state: got %b, expected 01", key_state); end
    key_in0 = 1'b0;
    repeat (14) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL rel_bounce_end: got %b, expected 00", key_state); end
  endtask

  task automatic test_bounce();
    int base;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      key_in1 = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    key_in1 = 1'b1;
    base = edge_n;
    exp_q.push_back('{at_edge: base + 10, en: 2'b10});
    repeat (14) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b10) begin fails++; $display("FAIL bounce_state: got %b, expected 10", key_state); end
    key_in1 = 1'b0;
    repeat (14) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL bounce_release: got %b, expected 00", key_state); end
  endtask

  task automatic test_simultaneous();
    int base;
    @(negedge clk);
    key_in1 = 1'b1;
    key_in0 = 1'b1;
    base = edge_n;
    exp_q.push_back('{at_edge: base + 10, en: 2'b11});
    repeat (12) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b11) begin fails++; $display("FAIL simul_state: got %b, expected 11", key_state); end
    key_in1 = 1'b0;
    key_in0 = 1'b0;
    repeat (14) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL simul_release: got %b, expected 00", key_state); end
  endtask

  task automatic test_reset_mid_check();
    int base;
    @(negedge clk);
    key_in0 = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({EN_out1, EN_out0, key_state} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_check: got EN=%b state=%b, expected 00/00", {EN_out1, EN_out0}, key_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base = edge_n;
    exp_q.push_back('{at_edge: base + 10, en: 2'b01});
    repeat (14) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b01) begin fails++; $display("FAIL after_reset_state: got %b, expected 01", key_state); end
    key_in0 = 1'b0;
    repeat (14) @(negedge clk);
    // Reset landing on the pulse cycle must swallow it; the still-held key re-qualifies once.
    key_in1 = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (EN_out1 !== 1'b0) begin fails++; $display("FAIL reset_mid_pulse: got %b, expected 0", EN_out1); end
    @(negedge clk);
    rst_n = 1'b1;
    base = edge_n;
    exp_q.push_back('{at_edge: base + 10, en: 2'b10});
    repeat (14) @(negedge clk);
    key_in1 = 1'b0;
    repeat (14) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL reset_pulse_end: got %b, expected 00", key_state); end
  endtask

  task automatic test_long_hold();
    int base;
    @(negedge clk);
    key_in1 = 1'b1;
    base = edge_n;
    exp_q.push_back('{at_edge: base + 10, en: 2'b10});
`ifdef KEY_REPEAT_EN
    for (int k = 30; k <= 50; k += 5)
      exp_q.push_back('{at_edge: base + k, en: 2'b10});
    repeat (50) @(negedge clk);
`else
    repeat (60) @(negedge clk);
`endif
    tests_run++;
    if (key_state !== 2'b10) begin fails++; $display("FAIL long_hold_state: got %b, expected 10", key_state); end
    key_in1 = 1'b0;
    repeat (14) @(negedge clk);
    tests_run++;
    if (key_state !== 2'b00) begin fails++; $display("FAIL long_hold_release: got %b, expected 00", key_state); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_bounce();
    test_simultaneous();
    test_reset_mid_check();
    test_long_hold();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL pending_pulses: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
